// File: rtl/fpga_boot_pkg.sv
// Shared types and defaults for the FPGA boot controller: state encoding,
// default timing constants and the phase-counter width helper.
package fpga_boot_pkg;

  localparam int unsigned DefDebounceCycles   = 250000;
  localparam int unsigned DefResetHoldCycles  = 16;
  localparam int unsigned DefFetchDelayCycles = 8;

  typedef enum logic [2:0] {
    StRst   = 3'd0,
    StHold  = 3'd1,
    StWait  = 3'd2,
    StRun   = 3'd3,
    StPause = 3'd4
  } boot_state_e;

  // Counter width for a terminal count of n; at least one bit even for n = 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/fpga_boot_ctrl_if.sv
// Button inputs and core-control outputs of the boot controller.
interface fpga_boot_ctrl_if;
  logic       btn_reset_i;
  logic       btn_run_i;
  logic       core_rst_no;
  logic       fetch_enable_o;
  logic [2:0] state_o;

  modport master (
    output btn_reset_i, btn_run_i,
    input  core_rst_no, fetch_enable_o, state_o
  );

  modport slave (
    input  btn_reset_i, btn_run_i,
    output core_rst_no, fetch_enable_o, state_o
  );
endinterface

// File: rtl/fpga_debounce.sv
// Two-flop synchronizer plus counter debouncer for one raw button, with a
// registered single-cycle pulse on each accepted rising edge.
module fpga_debounce
  import fpga_boot_pkg::*;
#(
  parameter int unsigned CYCLES = DefDebounceCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic db_o,
  output logic rise_o
);

  localparam int unsigned CntW = cnt_width(CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            rise_q, rise_d;

  // Counter only advances while the synchronized level disagrees with db_q.
  always_comb begin
    cnt_d  = '0;
    db_d   = db_q;
    rise_d = 1'b0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CntLast) begin
        db_d   = sync_q[1];
        rise_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/fpga_boot_ctrl.sv
// Boot sequencer: holds the core in reset, releases it, enables fetch, and
// toggles run/pause on debounced button events.
module fpga_boot_ctrl
  import fpga_boot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = DefDebounceCycles,
  parameter int unsigned RESET_HOLD_CYCLES  = DefResetHoldCycles,
  parameter int unsigned FETCH_DELAY_CYCLES = DefFetchDelayCycles
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fpga_boot_ctrl_if.slave  boot
);

  if (DEBOUNCE_CYCLES == 0 || RESET_HOLD_CYCLES == 0 || FETCH_DELAY_CYCLES == 0) begin : g_bad_param
    $error("fpga_boot_ctrl: cycle parameters must all be at least 1");
  end

  localparam int unsigned HoldW = cnt_width(RESET_HOLD_CYCLES);
  localparam int unsigned WaitW = cnt_width(FETCH_DELAY_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD_CYCLES - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(FETCH_DELAY_CYCLES - 1);

  logic reset_db, unused_reset_rise;
  logic run_evt, unused_run_level;

  fpga_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (boot.btn_reset_i),
    .db_o   (reset_db),
    .rise_o (unused_reset_rise)
  );

  fpga_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (boot.btn_run_i),
    .db_o   (unused_run_level),
    .rise_o (run_evt)
  );

  boot_state_e      state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             core_rst_q, fetch_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:   if (!reset_db) state_d = StHold;
      StHold:  if (hold_cnt_q == HoldLast) state_d = StWait;
      StWait:  if (wait_cnt_q == WaitLast) state_d = StRun;
      StRun:   if (run_evt) state_d = StPause;
      StPause: if (run_evt) state_d = StRun;
      default: state_d = StRst;
    endcase
    // Reset button wins over any same-cycle run event.
    if (reset_db) state_d = StRst;

    // Counters sit at zero outside their phase, so every entry starts at zero.
    hold_cnt_d = '0;
    wait_cnt_d = '0;
    if (state_q == StHold && state_d == StHold && hold_cnt_q != HoldLast) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
    if (state_q == StWait && state_d == StWait && wait_cnt_q != WaitLast) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Outputs are decoded from state_d so they move on the same edge as the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StRst;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      core_rst_q <= 1'b0;
      fetch_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      core_rst_q <= (state_d == StWait) || (state_d == StRun) || (state_d == StPause);
      fetch_q    <= (state_d == StRun);
    end
  end

  assign boot.core_rst_no    = core_rst_q;
  assign boot.fetch_enable_o = fetch_q;
  assign boot.state_o        = state_q;

endmodule

// File: tb/tb_fpga_boot_ctrl.sv
// Scoreboard bench for fpga_boot_ctrl: stimulus queues expected state changes
// with their cycle numbers, a negedge monitor pops and checks each change.
module tb_fpga_boot_ctrl;

  localparam logic [2:0] SRst   = 3'd0;
  localparam logic [2:0] SHold  = 3'd1;
  localparam logic [2:0] SWait  = 3'd2;
  localparam logic [2:0] SRun   = 3'd3;
  localparam logic [2:0] SPause = 3'd4;

  typedef struct {
    int         cyc;    // -1: change is asynchronous, cycle not checked
    logic [2:0] st;
    logic       rst_n;
    logic       fe;
    string      name;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_ni = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  fpga_boot_ctrl_if bif ();

  fpga_boot_ctrl #(
    .DEBOUNCE_CYCLES    (4),
    .RESET_HOLD_CYCLES  (16),
    .FETCH_DELAY_CYCLES (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .boot   (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic [2:0] st, input string nm);
    exp_t e;
    e.cyc   = c;
    e.st    = st;
    e.rst_n = (st == SWait) || (st == SRun) || (st == SPause);
    e.fe    = (st == SRun);
    e.name  = nm;
    q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (q.size() != 0 && n < maxc) begin
      tick(1);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expected changes pending (next %s), required 0",
               q.size(), q[0].name);
      q.delete();
    end
  endtask

  initial begin : monitor
    logic [2:0] prev;
    bit         first;
    exp_t       e;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (first || bif.state_o != prev) begin
        first = 1'b0;
        prev  = bif.state_o;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: state=%0d at cycle %0d, required no change",
                   bif.state_o, cyc);
        end else begin
          e = q.pop_front();
          if (bif.state_o !== e.st || bif.core_rst_no !== e.rst_n ||
              bif.fetch_enable_o !== e.fe || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL %s: got state=%0d rst_n=%b fe=%b cycle=%0d, required state=%0d rst_n=%b fe=%b cycle=%0d",
                     e.name, bif.state_o, bif.core_rst_no, bif.fetch_enable_o, cyc,
                     e.st, e.rst_n, e.fe, e.cyc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b;
    bif.btn_reset_i = 1'b0;
    bif.btn_run_i   = 1'b0;
    push(-1, SRst, "reset_state");
    #1 rst_ni = 1'b0;
    tick(3);

    // Power-up sequence
    b = cyc;
    rst_ni = 1'b1;
    push(b + 1, SHold, "pwr_hold");
    push(b + 17, SWait, "pwr_wait");
    push(b + 25, SRun, "pwr_run");
    drain(40);

    // 3-cycle glitch is ignored; 8-cycle press pauses, second press resumes
    bif.btn_run_i = 1'b1;
    tick(3);
    bif.btn_run_i = 1'b0;
    tick(12);
    b = cyc;
    bif.btn_run_i = 1'b1;
    push(b + 7, SPause, "run_to_pause");
    tick(8);
    bif.btn_run_i = 1'b0;
    drain(20);
    tick(10);
    b = cyc;
    bif.btn_run_i = 1'b1;
    push(b + 7, SRun, "pause_to_run");
    tick(8);
    bif.btn_run_i = 1'b0;
    drain(20);
    tick(10);

    // Reset button in RUN, then the full sequence again on release
    b = cyc;
    bif.btn_reset_i = 1'b1;
    push(b + 7, SRst, "btn_rst");
    tick(10);
    bif.btn_reset_i = 1'b0;
    push(b + 17, SHold, "btn_hold");
    push(b + 33, SWait, "btn_wait");
    push(b + 41, SRun, "btn_run");
    drain(50);
    tick(5);

    // Reset and run debounced on the same cycle while paused
    b = cyc;
    bif.btn_run_i = 1'b1;
    push(b + 7, SPause, "pre_simul_pause");
    tick(8);
    bif.btn_run_i = 1'b0;
    drain(20);
    tick(10);
    b = cyc;
    bif.btn_run_i   = 1'b1;
    bif.btn_reset_i = 1'b1;
    push(b + 7, SRst, "simul_rst");
    tick(10);
    bif.btn_run_i   = 1'b0;
    bif.btn_reset_i = 1'b0;
    push(b + 17, SHold, "simul_hold");
    push(b + 33, SWait, "simul_wait");
    push(b + 41, SRun, "simul_run");
    drain(50);
    tick(5);

    // Run press during HOLD is discarded
    b = cyc;
    bif.btn_reset_i = 1'b1;
    push(b + 7, SRst, "hold_press_rst");
    tick(10);
    bif.btn_reset_i = 1'b0;
    push(b + 17, SHold, "hold_press_hold");
    push(b + 33, SWait, "hold_press_wait");
    push(b + 41, SRun, "hold_press_run");
    tick(8);
    bif.btn_run_i = 1'b1;
    tick(8);
    bif.btn_run_i = 1'b0;
    drain(40);
    tick(10);

    // Half-cycle rst_ni pulse in WAIT
    b = cyc;
    bif.btn_reset_i = 1'b1;
    push(b + 7, SRst, "pre_async_rst");
    tick(10);
    bif.btn_reset_i = 1'b0;
    push(b + 17, SHold, "pre_async_hold");
    push(b + 33, SWait, "pre_async_wait");
    tick(25);
    drain(10);
    b = cyc;
    push(-1, SRst, "async_rst");
    push(b + 1, SHold, "async_hold");
    push(b + 17, SWait, "async_wait");
    push(b + 25, SRun, "async_run");
    #1 rst_ni = 1'b0;
    #5 rst_ni = 1'b1;
    drain(40);
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
